// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised Hack register-file RAM.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } ram_state_t;

    // Address width that stays at least one bit for the smallest depths.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addr_decoder.sv
// One-hot word select for a depth that need not be a power of two,
// plus a flag telling whether the address maps onto a real word.
module addr_decoder
    import ram_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = safe_clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  sel,
    output logic              in_range
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    // Decode the address; out-of-range addresses select no word.
    always_comb begin
        sel      = '0;
        in_range = ({1'b0, addr} < DEPTH_W);
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = (addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/ram_n_clr.sv
// Parametrised register-file RAM with a one-word-per-cycle hardware clear
// sweep and a registered out-of-range write flag.
module ram_n_clr
    import ram_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = safe_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

    ram_state_t               state_q, state_d;
    logic [ADDR_W-1:0]        ptr_q, ptr_d;
    logic                     addr_err_q, addr_err_d;

    logic                     sweep_s;
    logic                     wr_en_s;
    logic [ADDR_W-1:0]        wr_addr_s;
    logic [DATA_W-1:0]        wr_data_s;
    logic [DEPTH-1:0]         sel_s;
    logic                     wr_in_range_s;
    logic                     rd_ok_s;
    logic [DEPTH-1:0][DATA_W-1:0] mem_s;

    assign sweep_s   = (state_q == SWEEP);
    assign wr_addr_s = sweep_s ? ptr_q : address;
    assign wr_data_s = sweep_s ? {DATA_W{1'b0}} : data_in;
    // clear in IDLE takes priority over a coincident load.
    assign wr_en_s   = sweep_s | (load & ~clear);

    addr_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr     (wr_addr_s),
        .sel      (sel_s),
        .in_range (wr_in_range_s)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DATA_W-1:0] word_q;

        // Storage word: written by a legal load or zeroed by the sweep.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (sel_s[gi] && wr_en_s) begin
                word_q <= wr_data_s;
            end
        end

        assign mem_s[gi] = word_q;
    end

    // Next-state logic for the clear sweep and the out-of-range flag.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        addr_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end else begin
                    addr_err_d = load & ~wr_in_range_s;
                end
            end
            SWEEP: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_ok_s = ({1'b0, address} < DEPTH_W);

    // Zero-latency read; unmapped addresses read as zero.
    always_comb begin
        data_out = '0;
        if (rd_ok_s) begin
            data_out = mem_s[address];
        end else begin
            data_out = '0;
        end
    end

    assign busy     = sweep_s;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_n_clr.sv
// Directed self-checking bench for ram_n_clr at DEPTH=8 and DEPTH=6.
module tb_ram_n_clr;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        load8, clr8, busy8, err8;
    logic [2:0]  addr8;
    logic [15:0] din8, dout8;

    logic        load6, clr6, busy6, err6;
    logic [2:0]  addr6;
    logic [15:0] din6, dout6;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    always #5 clk = ~clk;

    ram_n_clr #(.DATA_W(16), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .load(load8), .address(addr8), .data_in(din8),
        .clear(clr8), .data_out(dout8), .busy(busy8), .addr_err(err8)
    );

    ram_n_clr #(.DATA_W(16), .DEPTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .load(load6), .address(addr6), .data_in(din6),
        .clear(clr6), .data_out(dout6), .busy(busy6), .addr_err(err6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        load8 = 1'b0; clr8 = 1'b0; addr8 = 3'd0; din8 = 16'h0000;
        load6 = 1'b0; clr6 = 1'b0; addr6 = 3'd0; din6 = 16'h0000;
        #2;

        // 1: reset state
        for (int a = 0; a < 8; a++) begin
            addr8 = 3'(a);
            #1;
            chk($sformatf("rst_rd%0d", a), {16'h0, dout8}, 32'h0);
        end
        chk("rst_busy", {31'h0, busy8}, 32'h0);
        chk("rst_err", {31'h0, err8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 2: writes and same-cycle read
        addr8 = 3'd3; din8 = 16'hA5A5; load8 = 1'b1;
        #1;
        chk("same_cycle_rd3", {16'h0, dout8}, 32'h0);
        tick();
        addr8 = 3'd7; din8 = 16'h1234; load8 = 1'b1;
        tick();
        load8 = 1'b0; addr8 = 3'd3;
        #1;
        chk("rd3", {16'h0, dout8}, 32'hA5A5);
        addr8 = 3'd7;
        #1;
        chk("rd7", {16'h0, dout8}, 32'h1234);
        chk("wr_err", {31'h0, err8}, 32'h0);

        // 3: DEPTH=6 out-of-range handling
        addr6 = 3'd5; din6 = 16'h1111; load6 = 1'b1;
        tick();
        addr6 = 3'd6; din6 = 16'hFFFF; load6 = 1'b1;
        #1;
        chk("d6_rd6", {16'h0, dout6}, 32'h0);
        chk("d6_err_pre", {31'h0, err6}, 32'h0);
        tick();
        load6 = 1'b0; addr6 = 3'd0;
        #1;
        chk("d6_err_a6", {31'h0, err6}, 32'h1);
        tick();
        chk("d6_err_clr", {31'h0, err6}, 32'h0);
        addr6 = 3'd7; load6 = 1'b1;
        tick();
        load6 = 1'b0; addr6 = 3'd6;
        #1;
        chk("d6_err_a7", {31'h0, err6}, 32'h1);
        chk("d6_rd6b", {16'h0, dout6}, 32'h0);
        tick();
        chk("d6_rdonly_noerr", {31'h0, err6}, 32'h0);
        for (int a = 0; a < 6; a++) begin
            addr6 = 3'(a);
            #1;
            chk($sformatf("d6_word%0d", a), {16'h0, dout6}, (a == 5) ? 32'h1111 : 32'h0);
        end

        // 4: fill, sweep, drop a mid-sweep load, ignore a mid-sweep clear
        for (int a = 0; a < 8; a++) begin
            addr8 = 3'(a); din8 = 16'h1000 + 16'(a); load8 = 1'b1;
            tick();
        end
        load8 = 1'b0; addr8 = 3'd6;
        #1;
        chk("fill6", {16'h0, dout8}, 32'h1006);
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20 && busy8; k++) begin
            cnt++;
            load8 = 1'b0; clr8 = 1'b0;
            if (k == 2) begin
                addr8 = 3'd0;
                #1;
                chk("sweep_rd_below", {16'h0, dout8}, 32'h0);
                addr8 = 3'd5;
                #1;
                chk("sweep_rd_above", {16'h0, dout8}, 32'h1005);
                addr8 = 3'd0; din8 = 16'hDEAD; load8 = 1'b1;
            end else if (k == 4) begin
                clr8 = 1'b1;
            end
            tick();
        end
        load8 = 1'b0; clr8 = 1'b0;
        chk("sweep_cycles", cnt, 32'd8);
        for (int a = 0; a < 8; a++) begin
            addr8 = 3'(a);
            #1;
            chk($sformatf("swept%0d", a), {16'h0, dout8}, 32'h0);
        end

        // 5: clear and load together
        addr8 = 3'd2; din8 = 16'hBEEF; load8 = 1'b1; clr8 = 1'b1;
        tick();
        load8 = 1'b0; clr8 = 1'b0;
        #1;
        chk("cl_busy", {31'h0, busy8}, 32'h1);
        chk("cl_word2", {16'h0, dout8}, 32'h0);
        cnt = 0;
        for (int k = 0; k < 20 && busy8; k++) begin
            cnt++;
            tick();
        end
        chk("cl_sweep_cycles", cnt, 32'd8);
        chk("cl_word2_end", {16'h0, dout8}, 32'h0);

        // 6: reset in the middle of a sweep
        for (int a = 0; a < 8; a++) begin
            addr8 = 3'(a); din8 = 16'h5A00 + 16'(a); load8 = 1'b1;
            tick();
        end
        load8 = 1'b0;
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy", {31'h0, busy8}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'h0, busy8}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            addr8 = 3'(a);
            #1;
            chk($sformatf("rst_mid_word%0d", a), {16'h0, dout8}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        addr8 = 3'd5; din8 = 16'h0C0C; load8 = 1'b1;
        tick();
        load8 = 1'b0;
        #1;
        chk("post_rst_wr", {16'h0, dout8}, 32'h0C0C);
        chk("post_rst_busy", {31'h0, busy8}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
